// File: rtl/spi_ctl_if.sv
// SPI host-header bundle between the MCU (master) and the control responder (slave).
interface spi_ctl_if;
  logic COM_CLK;
  logic COM_CS;
  logic COM_MOSI;
  logic COM_MISO;
  logic COM_INTERUPT;

  modport master (
    output COM_CLK,
    output COM_CS,
    output COM_MOSI,
    input  COM_MISO,
    input  COM_INTERUPT
  );

  modport slave (
    input  COM_CLK,
    input  COM_CS,
    input  COM_MOSI,
    output COM_MISO,
    output COM_INTERUPT
  );
endinterface

// File: rtl/spi_ctl_responder.sv
// SPI mode-0 register responder driving the LED and analog-switch controls.
// Define SPI_READBACK_EN to include the read path on COM_MISO.
module spi_ctl_responder (
  input  logic        clk,
  input  logic        rst_n,
  spi_ctl_if.slave    spi,
  output logic        LED_R,
  output logic        LED_G,
  output logic        LED_B,
  output logic        INT_IN_SIG_CTL,
  output logic        INT_IN_P_CTL,
  output logic        INT_IN_N_CTL
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic        sclk_d_reg, cs_d_reg;
  logic [4:0]  bit_cnt_reg;
  logic [6:0]  rx_reg;
  logic        wr_reg;
  logic [6:0]  addr_reg;
  logic [2:0]  led_reg, ctl_reg;
  logic        irq_reg;
  logic        miso_next;

  logic sclk_rise, sclk_fall, cs_high, cs_fall, mosi_s;
  logic [6:0] addr_in;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_d_reg;
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_d_reg;
  assign cs_high   = cs_sync_reg[1];
  assign cs_fall   = ~cs_sync_reg[1] & cs_d_reg;
  assign mosi_s    = mosi_sync_reg[1];
  assign addr_in   = {rx_reg[5:0], mosi_s};

  // CS synchronizer resets to the idle-high level so reset release is not seen as a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= 2'b00;
      sclk_d_reg    <= 1'b0;
      cs_sync_reg   <= 2'b11;
      cs_d_reg      <= 1'b1;
      mosi_sync_reg <= 2'b00;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], spi.COM_CLK};
      sclk_d_reg    <= sclk_sync_reg[1];
      cs_sync_reg   <= {cs_sync_reg[0], spi.COM_CS};
      cs_d_reg      <= cs_sync_reg[1];
      mosi_sync_reg <= {mosi_sync_reg[0], spi.COM_MOSI};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cs_high) begin
      state_next = IDLE;
    end else if (cs_fall) begin
      state_next = ADDR;
    end else begin
      case (state_reg)
        ADDR:    if (sclk_rise && bit_cnt_reg == 5'd7)  state_next = DATA;
        DATA:    if (sclk_rise && bit_cnt_reg == 5'd15) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  localparam logic [7:0] ID_VALUE = 8'h5A;
  logic [7:0] tx_reg;
  logic [7:0] rdata;

  always_comb begin
    case (addr_in)
      7'h00:   rdata = {5'b0, led_reg};
      7'h01:   rdata = {5'b0, ctl_reg};
      7'h02:   rdata = ID_VALUE;
      default: rdata = 8'h00;
    endcase
  end

  // The load on the 8th rise stands in for the following fall, so that fall must not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg <= 8'h00;
    end else if (!cs_high && !cs_fall) begin
      if (sclk_rise && state_reg == ADDR && bit_cnt_reg == 5'd7)
        tx_reg <= rdata;
      else if (sclk_fall && (state_reg == DATA || state_reg == DONE) && bit_cnt_reg != 5'd8)
        tx_reg <= {tx_reg[6:0], 1'b0};
    end
  end

  always_comb begin
    miso_next = 1'b0;
    if (!cs_high && (state_reg == DATA || state_reg == DONE))
      miso_next = tx_reg[7];
  end
`else
  always_comb begin
    miso_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= 5'd0;
      rx_reg      <= 7'd0;
      wr_reg      <= 1'b0;
      addr_reg    <= 7'd0;
      led_reg     <= 3'd0;
      ctl_reg     <= 3'd0;
      irq_reg     <= 1'b0;
    end else if (cs_high) begin
      bit_cnt_reg <= 5'd0;
    end else if (cs_fall) begin
      bit_cnt_reg <= 5'd0;
      irq_reg     <= 1'b0;
    end else if (sclk_rise && (state_reg == ADDR || state_reg == DATA)) begin
      bit_cnt_reg <= bit_cnt_reg + 5'd1;
      rx_reg      <= {rx_reg[5:0], mosi_s};
      if (state_reg == ADDR && bit_cnt_reg == 5'd7) begin
        wr_reg   <= rx_reg[6];
        addr_reg <= addr_in;
      end
      if (state_reg == DATA && bit_cnt_reg == 5'd15 && wr_reg) begin
        case (addr_reg)
          7'h00: begin
            led_reg <= {rx_reg[1:0], mosi_s};
            irq_reg <= 1'b1;
          end
          7'h01: begin
            ctl_reg <= {rx_reg[1:0], mosi_s};
            irq_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.COM_MISO     = miso_next;
  assign spi.COM_INTERUPT = irq_reg;
  assign LED_R            = led_reg[2];
  assign LED_G            = led_reg[1];
  assign LED_B            = led_reg[0];
  assign INT_IN_SIG_CTL   = ctl_reg[2];
  assign INT_IN_P_CTL     = ctl_reg[1];
  assign INT_IN_N_CTL     = ctl_reg[0];
endmodule

// File: tb/tb_spi_ctl_responder.sv
// Scoreboard bench for spi_ctl_responder: drives SPI frames and checks outputs and read data.
module tb_spi_ctl_responder;
  logic clk;
  logic rst_n;
  logic LED_R, LED_G, LED_B, INT_IN_SIG_CTL, INT_IN_P_CTL, INT_IN_N_CTL;

  spi_ctl_if spi ();

  spi_ctl_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi            (spi.slave),
    .LED_R          (LED_R),
    .LED_G          (LED_G),
    .LED_B          (LED_B),
    .INT_IN_SIG_CTL (INT_IN_SIG_CTL),
    .INT_IN_P_CTL   (INT_IN_P_CTL),
    .INT_IN_N_CTL   (INT_IN_N_CTL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] led_m = 3'd0;
  logic [2:0] ctl_m = 3'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  function automatic logic [7:0] obs();
    return {LED_R, LED_G, LED_B, INT_IN_SIG_CTL, INT_IN_P_CTL, INT_IN_N_CTL,
            spi.COM_MISO, spi.COM_INTERUPT};
  endfunction

  function automatic logic [7:0] exp_obs(input logic irq);
    return {led_m, ctl_m, 1'b0, irq};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [6:0] addr);
`ifdef SPI_READBACK_EN
    case (addr)
      7'h00:   return {5'b0, led_m};
      7'h01:   return {5'b0, ctl_m};
      7'h02:   return 8'h5A;
      default: return 8'h00;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic spi_bit(input logic b, output logic m);
    spi.COM_MOSI = b;
    repeat (8) @(negedge clk);
    m = spi.COM_MISO;
    spi.COM_CLK = 1'b1;
    repeat (8) @(negedge clk);
    spi.COM_CLK = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] bits, input int nbits, output logic [7:0] rd);
    logic m;
    rd = 8'h00;
    spi.COM_CS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(bits[nbits-1-i], m);
      if (i >= 8 && i < 16) rd = {rd[6:0], m};
    end
    repeat (8) @(negedge clk);
    spi.COM_CS   = 1'b1;
    spi.COM_MOSI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [7:0] data, input int nbits,
                          input logic [7:0] extra);
    logic [7:0] rd;
    logic       mapped;
    mapped = (nbits >= 16) && (addr == 7'h00 || addr == 7'h01);
    if (mapped && addr == 7'h00) led_m = data[2:0];
    if (mapped && addr == 7'h01) ctl_m = data[2:0];
    sb_push($sformatf("wr_%02h_%02h_n%0d", addr, data, nbits), exp_obs(mapped));
    spi_frame({1'b1, addr, data, extra} >> (24 - nbits), nbits, rd);
    $display("[TB] write addr=%02h data=%02h bits=%0d outs=%02h", addr, data, nbits, obs());
    sb_check(obs());
  endtask

  task automatic do_read(input logic [6:0] addr);
    logic [7:0] rd;
    sb_push($sformatf("rd_%02h", addr), exp_rd(addr));
    sb_push($sformatf("rd_%02h_outs", addr), exp_obs(1'b0));
    spi_frame({8'h00, 1'b0, addr, 8'h00}, 16, rd);
    $display("[TB] read  addr=%02h data=%02h outs=%02h", addr, rd, obs());
    sb_check(rd);
    sb_check(obs());
  endtask

  initial begin
    logic m;
    rst_n        = 1'b0;
    spi.COM_CLK  = 1'b0;
    spi.COM_CS   = 1'b1;
    spi.COM_MOSI = 1'b0;
    repeat (4) @(negedge clk);
    sb_push("reset_outs", 8'h00);
    sb_check(obs());
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_write(7'h00, 8'h05, 16, 8'h00);

    // Frame start clears the write flag; then reset lands mid-frame.
    spi.COM_CS = 1'b0;
    repeat (8) @(negedge clk);
    sb_push("irq_clear_on_cs_fall", exp_obs(1'b0));
    sb_check(obs());
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    led_m = 3'd0;
    ctl_m = 3'd0;
    sb_push("reset_mid_frame", 8'h00);
    sb_check(obs());
    spi.COM_CS   = 1'b1;
    spi.COM_MOSI = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] reset mid-frame outs=%02h", obs());

    do_write(7'h00, 8'h05, 16, 8'h00);
    do_write(7'h01, 8'h06, 16, 8'h00);
    do_read(7'h01);
    do_read(7'h02);
    do_read(7'h7F);
    do_read(7'h00);
    do_write(7'h02, 8'hFF, 16, 8'h00);
    do_write(7'h23, 8'h07, 16, 8'h00);
    do_write(7'h00, 8'h07, 12, 8'h00);
    do_read(7'h00);
    do_write(7'h01, 8'h01, 24, 8'hFF);
    do_read(7'h01);
    do_write(7'h00, 8'hF8, 16, 8'h00);
    do_read(7'h00);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      do_write(7'(k % 2), d, 16, 8'h00);
      do_read(7'(k % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
